// File: rtl/msk_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// msk_pkg : shared types and phase-step helper for the MSK modulator
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
package msk_pkg;

  typedef logic [1:0] quad_t;

  typedef enum logic {
    MODE_MSK = 1'b0,
    MODE_CW  = 1'b1
  } mode_e;

  // Phase increment per sample: round(2^phase_w / (4*sps)), i.e. a quarter turn per symbol
  function automatic logic [63:0] calc_step(input int phase_w, input int sps);
    logic [63:0] full;
    full = 64'd1 << phase_w;
    return (full + 64'(2 * sps)) / 64'(4 * sps);
  endfunction

endpackage
`default_nettype wire

// File: rtl/msk_sincos_lut.sv
`default_nettype none
// -----------------------------------------------------------------------------
// msk_sincos_lut : quarter-wave sine ROM with quadrant folding, 2 register stages
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
module msk_sincos_lut
  import msk_pkg::*;
#(
  parameter int OUT_W  = 16,
  parameter int LUT_AW = 10
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic [LUT_AW+1:0]       phase,
  output logic                    valid,
  output logic signed [OUT_W-1:0] cos_out,
  output logic signed [OUT_W-1:0] sin_out
);

  localparam int  N       = 1 << LUT_AW;
  localparam int  NA      = LUT_AW + 1;
  localparam real AMP     = (2.0 ** (OUT_W - 1)) - 1.0;
  localparam real HALF_PI = 1.5707963267948966;

  // N+1 entries so the exact peak at a quadrant edge is reachable by mirroring
  logic [OUT_W-1:0] rom [0:N];

  generate
    for (genvar k = 0; k <= N; k++) begin : g_rom
      localparam real ANG = HALF_PI * k / N;
      assign rom[k] = OUT_W'($rtoi(AMP * $sin(ANG) + 0.5));
    end
  endgenerate

  quad_t            quad;
  logic [NA-1:0]    idx;
  logic [NA-1:0]    idx_mirror;
  logic [OUT_W-1:0] sin_mag, cos_mag;
  logic             sin_neg, cos_neg, stage1_valid;

  always_comb begin
    quad       = phase[LUT_AW+1:LUT_AW];
    idx        = {1'b0, phase[LUT_AW-1:0]};
    idx_mirror = NA'(N) - idx;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sin_mag      <= '0;
      cos_mag      <= '0;
      sin_neg      <= 1'b0;
      cos_neg      <= 1'b0;
      stage1_valid <= 1'b0;
    end else begin
      stage1_valid <= en;
      if (en) begin
        sin_mag <= quad[0] ? rom[idx_mirror] : rom[idx];
        cos_mag <= quad[0] ? rom[idx] : rom[idx_mirror];
        sin_neg <= quad[1];
        cos_neg <= quad[1] ^ quad[0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid   <= 1'b0;
      sin_out <= '0;
      cos_out <= '0;
    end else begin
      valid <= stage1_valid;
      if (stage1_valid) begin
        sin_out <= sin_neg ? -$signed(sin_mag) : $signed(sin_mag);
        cos_out <= cos_neg ? -$signed(cos_mag) : $signed(cos_mag);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/msk_mod_gen.sv
`default_nettype none
// -----------------------------------------------------------------------------
// msk_mod_gen : MSK / CW baseband I/Q generator with per-symbol quadrant snap
// Rev 1.0 : initial release
// -----------------------------------------------------------------------------
module msk_mod_gen
  import msk_pkg::*;
#(
  parameter int SPS      = 80,
  parameter int PHASE_W  = 32,
  parameter int OUT_W    = 16,
  parameter int LUT_AW   = 10,
  parameter bit IDLE_BIT = 1'b0
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    enable,
  input  logic                    mode,
  input  logic                    s_bit_tvalid,
  output logic                    s_bit_tready,
  input  logic                    s_bit_tdata,
  output logic                    m_tvalid,
  output logic signed [OUT_W-1:0] i_out,
  output logic signed [OUT_W-1:0] q_out,
  output logic                    underrun
);

  localparam int                 CNT_W = $clog2(SPS);
  localparam logic [PHASE_W-1:0] STEP  = PHASE_W'(calc_step(PHASE_W, SPS));
  localparam logic [CNT_W-1:0]   LAST  = CNT_W'(SPS - 1);

  logic [CNT_W-1:0]   cnt;
  quad_t              quad, quad_next;
  logic               dir, active;
  logic [PHASE_W-1:0] acc;
  logic               at_last, cw;

  always_comb begin
    cw           = (mode == MODE_CW);
    at_last      = (cnt == LAST);
    s_bit_tready = enable & at_last & ~cw & ~reset;
    quad_next    = quad;
    if (active) quad_next = dir ? quad + 2'd1 : quad - 2'd1;
  end

  // Snapping acc to the quadrant at each boundary discards accumulated STEP rounding
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt      <= LAST;
      quad     <= '0;
      dir      <= 1'b0;
      active   <= 1'b0;
      acc      <= '0;
      underrun <= 1'b0;
    end else if (enable) begin
      if (at_last) begin
        quad   <= quad_next;
        acc    <= {quad_next, {(PHASE_W-2){1'b0}}};
        cnt    <= '0;
        active <= 1'b1;
        if (cw) begin
          dir <= 1'b1;
        end else if (s_bit_tvalid) begin
          dir <= s_bit_tdata;
        end else begin
          dir      <= IDLE_BIT;
          underrun <= 1'b1;
        end
      end else begin
        acc <= dir ? acc + STEP : acc - STEP;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  msk_sincos_lut #(
    .OUT_W  (OUT_W),
    .LUT_AW (LUT_AW)
  ) u_lut (
    .clk     (clk),
    .reset   (reset),
    .en      (enable),
    .phase   (acc[PHASE_W-1 -: LUT_AW+2]),
    .valid   (m_tvalid),
    .cos_out (i_out),
    .sin_out (q_out)
  );

endmodule
`default_nettype wire
